// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver with clock filter, frame checks and a read FIFO.
// Good bytes are queued; bad frames raise single-cycle error pulses.
module ps2_rx_fifo #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 3200,
  parameter int DEPTH          = 8
) (
  input  logic                       CLK,
  input  logic                       nRESET,
  input  logic                       PS2_CLK,
  input  logic                       PS2_DATA,
  output logic [7:0]                 DATA,
  output logic                       VALID,
  input  logic                       READY,
  output logic [$clog2(DEPTH+1)-1:0] COUNT,
  output logic                       PARITY_ERR,
  output logic                       FRAME_ERR,
  output logic                       OVERFLOW
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [FW-1:0] FMAX = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CMAX = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  logic          clk_s1;
  logic          clk_s2;
  logic          dat_s1;
  logic          dat_s2;
  logic          filt;
  logic [FW-1:0] fcnt;
  logic          fall;

  state_t        state;
  logic [7:0]    sh;
  logic [2:0]    bitcnt;
  logic          par;
  logic [TW-1:0] tcnt;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          push;
  logic          pop;
  logic          full;
  logic          push_ok;

  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= PS2_CLK;
      clk_s2 <= clk_s1;
      dat_s1 <= PS2_DATA;
      dat_s2 <= dat_s1;
    end
  end

  // filt follows clk_s2 only after FILTER_LEN consecutive differing samples
  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      filt <= 1'b1;
      fcnt <= '0;
      fall <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (clk_s2 == filt) begin
        fcnt <= '0;
      end else if (fcnt == FMAX) begin
        filt <= clk_s2;
        fcnt <= '0;
        fall <= ~clk_s2;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      state      <= S_IDLE;
      sh         <= 8'h00;
      bitcnt     <= 3'd0;
      par        <= 1'b0;
      tcnt       <= '0;
      PARITY_ERR <= 1'b0;
      FRAME_ERR  <= 1'b0;
    end else begin
      PARITY_ERR <= 1'b0;
      FRAME_ERR  <= 1'b0;
      if (state == S_IDLE || fall) begin
        tcnt <= '0;
      end else begin
        tcnt <= tcnt + 1'b1;
      end
      if (state != S_IDLE && !fall && tcnt == TMAX) begin
        state     <= S_IDLE;
        FRAME_ERR <= 1'b1;
      end else if (fall) begin
        unique case (state)
          S_IDLE: begin
            if (!dat_s2) begin
              state  <= S_DATA;
              bitcnt <= 3'd0;
            end
          end
          S_DATA: begin
            sh     <= {dat_s2, sh[7:1]};
            bitcnt <= bitcnt + 3'd1;
            if (bitcnt == 3'd7) begin
              state <= S_PAR;
            end
          end
          S_PAR: begin
            par   <= dat_s2;
            state <= S_STOP;
          end
          S_STOP: begin
            state <= S_IDLE;
            if (!dat_s2) begin
              FRAME_ERR <= 1'b1;
            end else if (!(^{sh, par})) begin
              PARITY_ERR <= 1'b1;
            end
          end
        endcase
      end
    end
  end

  assign push    = fall && state == S_STOP && dat_s2 && (^{sh, par});
  assign VALID   = COUNT != '0;
  assign pop     = VALID & READY;
  assign full    = COUNT == CMAX;
  assign push_ok = push & (~full | pop);
  assign DATA    = mem[rd_ptr];

  // when full, a same-cycle pop frees the slot the push writes into
  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      COUNT    <= '0;
      OVERFLOW <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 8'h00;
      end
    end else begin
      OVERFLOW <= push & full & ~pop;
      if (push_ok) begin
        mem[wr_ptr] <= sh;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push_ok && !pop) begin
        COUNT <= COUNT + 1'b1;
      end else if (!push_ok && pop) begin
        COUNT <= COUNT - 1'b1;
      end
    end
  end

endmodule
